enigma_tx_formatter: RTL and testbench

Downstream stage of the Enigma core: accepts the core's one-cycle `valid`/5-bit letter pulses, buffers them in a FIFO, and emits ASCII bytes to the UART transmitter over a valid/ready handshake. Output is grouped in the classic cipher layout: five letters, a space, and CR LF after every tenth group. The core has no backpressure, so this block absorbs rate mismatch and flags loss.

---
 rtl/enigma_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/enigma_tx_formatter.sv | 175 +++++++++++++++++
 tb/tb_enigma_tx_formatter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared constants, state encoding and letter-to-ASCII conversion for the
// Enigma output path.
package enigma_pkg;

    localparam int LETTER_W = 5;
    localparam int ALPHABET = 26;

    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_Q  = 8'h3F;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LETTER = 3'd1;
    localparam state_t ST_SP     = 3'd2;
    localparam state_t ST_CR     = 3'd3;
    localparam state_t ST_LF     = 3'd4;

    // Out-of-alphabet indices become '?' so corruption stays visible on the line.
    function automatic logic [7:0] letter_to_ascii(input logic [LETTER_W-1:0] idx);
        logic [7:0] byte_s;
        if (idx < LETTER_W'(ALPHABET)) begin
            byte_s = ASCII_A + {3'b000, idx};
        end else begin
            byte_s = ASCII_Q;
        end
        return byte_s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push while full is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == (AW+1)'(0));
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rd_data   = mem_r[rd_ptr_r];
    assign level     = count_r;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/enigma_tx_formatter.sv
// Buffers Enigma core letters and streams them to the UART as ASCII in
// five-letter groups with CR LF line breaks.
module enigma_tx_formatter
    import enigma_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int GROUP       = 5,
    parameter int LINE_GROUPS = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [LETTER_W-1:0]     char_in,
    input  logic                    flush,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow
);

    localparam int LCW = $clog2(GROUP + 1);
    localparam int GCW = $clog2(LINE_GROUPS + 1);
    localparam logic [LCW-1:0] LETTER_END = LCW'(GROUP);
    localparam logic [GCW-1:0] GROUP_END  = GCW'(LINE_GROUPS - 1);

    logic [LETTER_W-1:0] head_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                pop_s;
    logic                hs_s;
    logic                drop_s;
    logic                flush_clr_s;

    state_t              state_r, state_nxt_s;
    logic [LCW-1:0]      letter_cnt_r, letter_cnt_nxt_s;
    logic [GCW-1:0]      group_cnt_r, group_cnt_nxt_s;
    logic [7:0]          tx_data_r, tx_data_nxt_s;
    logic                tx_valid_r, tx_valid_nxt_s;
    logic                flush_pend_r;
    logic                overflow_r;

    sync_fifo #(
        .WIDTH (LETTER_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (valid_in),
        .wr_data (char_in),
        .pop     (pop_s),
        .rd_data (head_s),
        .level   (level),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign hs_s     = tx_valid_r && tx_ready;
    assign drop_s   = valid_in && fifo_full_s && !pop_s;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign overflow = overflow_r;

    // Formatter FSM: separators are decided just before the next letter leaves.
    always_comb begin
        state_nxt_s      = state_r;
        letter_cnt_nxt_s = letter_cnt_r;
        group_cnt_nxt_s  = group_cnt_r;
        tx_data_nxt_s    = tx_data_r;
        tx_valid_nxt_s   = tx_valid_r;
        pop_s            = 1'b0;
        flush_clr_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    if ((letter_cnt_r == LETTER_END) && (group_cnt_r == GROUP_END)) begin
                        state_nxt_s    = ST_CR;
                        tx_data_nxt_s  = ASCII_CR;
                        tx_valid_nxt_s = 1'b1;
                    end else if (letter_cnt_r == LETTER_END) begin
                        state_nxt_s    = ST_SP;
                        tx_data_nxt_s  = ASCII_SP;
                        tx_valid_nxt_s = 1'b1;
                    end else begin
                        pop_s          = 1'b1;
                        state_nxt_s    = ST_LETTER;
                        tx_data_nxt_s  = letter_to_ascii(head_s);
                        tx_valid_nxt_s = 1'b1;
                    end
                end else if (flush_pend_r) begin
                    if ((letter_cnt_r != {LCW{1'b0}}) || (group_cnt_r != {GCW{1'b0}})) begin
                        state_nxt_s    = ST_CR;
                        tx_data_nxt_s  = ASCII_CR;
                        tx_valid_nxt_s = 1'b1;
                    end else begin
                        flush_clr_s    = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LETTER: begin
                if (hs_s) begin
                    letter_cnt_nxt_s = letter_cnt_r + LCW'(1);
                    state_nxt_s      = ST_IDLE;
                    tx_valid_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_LETTER;
                end
            end
            ST_SP: begin
                if (hs_s) begin
                    letter_cnt_nxt_s = {LCW{1'b0}};
                    group_cnt_nxt_s  = group_cnt_r + GCW'(1);
                    pop_s            = 1'b1;
                    state_nxt_s      = ST_LETTER;
                    tx_data_nxt_s    = letter_to_ascii(head_s);
                end else begin
                    state_nxt_s = ST_SP;
                end
            end
            ST_CR: begin
                if (hs_s) begin
                    state_nxt_s   = ST_LF;
                    tx_data_nxt_s = ASCII_LF;
                end else begin
                    state_nxt_s = ST_CR;
                end
            end
            ST_LF: begin
                if (hs_s) begin
                    letter_cnt_nxt_s = {LCW{1'b0}};
                    group_cnt_nxt_s  = {GCW{1'b0}};
                    if (flush_pend_r) begin
                        flush_clr_s    = 1'b1;
                        state_nxt_s    = ST_IDLE;
                        tx_valid_nxt_s = 1'b0;
                    end else begin
                        pop_s          = 1'b1;
                        state_nxt_s    = ST_LETTER;
                        tx_data_nxt_s  = letter_to_ascii(head_s);
                    end
                end else begin
                    state_nxt_s = ST_LF;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                tx_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered UART outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            letter_cnt_r <= {LCW{1'b0}};
            group_cnt_r  <= {GCW{1'b0}};
            tx_data_r    <= 8'h00;
            tx_valid_r   <= 1'b0;
            flush_pend_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            letter_cnt_r <= letter_cnt_nxt_s;
            group_cnt_r  <= group_cnt_nxt_s;
            tx_data_r    <= tx_data_nxt_s;
            tx_valid_r   <= tx_valid_nxt_s;
            flush_pend_r <= (flush_pend_r && !flush_clr_s) || flush;
            overflow_r   <= overflow_r || drop_s;
        end
    end

endmodule

// File: tb/tb_enigma_tx_formatter.sv
// Directed self-checking bench for enigma_tx_formatter: grouping, line breaks,
// backpressure/overflow, flush, '?' mapping, full push+pop and async reset.
module tb_enigma_tx_formatter;

    localparam int DEPTH       = 16;
    localparam int GROUP       = 5;
    localparam int LINE_GROUPS = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in;
    logic [4:0] char_in;
    logic       flush;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [4:0] level;
    logic       overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [4:0] sent[$];

    enigma_tx_formatter #(
        .DEPTH       (DEPTH),
        .GROUP       (GROUP),
        .LINE_GROUPS (LINE_GROUPS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .char_in  (char_in),
        .flush    (flush),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Byte capture on every completed handshake.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            got.push_back(tx_data);
        end
    end

    // Expected byte stream for the letters in sent, starting from cleared counters.
    function automatic void model_build();
        exp_q.delete();
        for (int i = 0; i < sent.size(); i++) begin
            if (i > 0 && (i % GROUP) == 0) begin
                if ((i % (GROUP * LINE_GROUPS)) == 0) begin
                    exp_q.push_back(8'h0D);
                    exp_q.push_back(8'h0A);
                end else begin
                    exp_q.push_back(8'h20);
                end
            end
            exp_q.push_back((sent[i] < 5'd26) ? (8'h41 + 8'(sent[i])) : 8'h3F);
        end
    endfunction

    task automatic push_letter(input logic [4:0] c);
        valid_in = 1'b1;
        char_in  = c;
        sent.push_back(c);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        ok = (got.size() >= n);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        valid_in = 1'b0;
        char_in  = 5'd0;
        flush    = 1'b0;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        sent.delete();
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", tx_valid); else pass_cnt++;
        total_cnt++;
        if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else pass_cnt++;
        total_cnt++;
        if (level !== 5'd0) $display("FAIL reset_level got %0d want 0", level); else pass_cnt++;
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass_cnt++;
    endtask

    task automatic test_group();
        logic [7:0] exp_grp [7] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h20, 8'h46};
        logic [7:0] g;
        bit ok;
        do_reset();
        for (int i = 0; i < 6; i++) push_letter(5'(i));
        wait_bytes(7, 60, ok);
        total_cnt++;
        if (!ok) $display("FAIL group_timeout got %0d bytes want 7", got.size()); else pass_cnt++;
        idle(10);
        total_cnt++;
        if (got.size() != 7) $display("FAIL group_no_trailing got %0d bytes want 7", got.size()); else pass_cnt++;
        for (int i = 0; i < 7; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            total_cnt++;
            if (g !== exp_grp[i]) $display("FAIL group_byte%0d got %h want %h", i, g, exp_grp[i]); else pass_cnt++;
        end
    endtask

    task automatic test_line();
        logic [7:0] g;
        bit ok;
        do_reset();
        for (int i = 0; i < 56; i++) begin
            push_letter(5'(i % 26));
            idle(2);
        end
        model_build();
        wait_bytes(exp_q.size(), 200, ok);
        total_cnt++;
        if (!ok) $display("FAIL line_timeout got %0d bytes want %0d", got.size(), exp_q.size()); else pass_cnt++;
        idle(10);
        total_cnt++;
        if (got.size() != 68) $display("FAIL line_count got %0d want 68", got.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            total_cnt++;
            if (g !== exp_q[i]) $display("FAIL line_byte%0d got %h want %h", i, g, exp_q[i]); else pass_cnt++;
        end
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL line_overflow got %b want 0", overflow); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [7:0] g;
        bit ok;
        bit stable;
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) push_letter(5'(i));
        // One letter already sits in the output register, so the 18th is the one lost.
        valid_in = 1'b1;
        char_in  = 5'd17;
        @(posedge clk); #1;
        valid_in = 1'b0;
        stable = 1'b1;
        repeat (4) begin
            if (!(tx_valid === 1'b1 && tx_data === 8'h41)) stable = 1'b0;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (!stable) $display("FAIL bp_hold got valid=%b data=%h want 1/41", tx_valid, tx_data); else pass_cnt++;
        total_cnt++;
        if (level !== 5'd16) $display("FAIL bp_level got %0d want 16", level); else pass_cnt++;
        total_cnt++;
        if (overflow !== 1'b1) $display("FAIL bp_overflow got %b want 1", overflow); else pass_cnt++;
        total_cnt++;
        if (got.size() != 0) $display("FAIL bp_no_bytes got %0d want 0", got.size()); else pass_cnt++;
        tx_ready = 1'b1;
        model_build();
        wait_bytes(exp_q.size(), 100, ok);
        idle(10);
        total_cnt++;
        if (got.size() != exp_q.size()) $display("FAIL bp_count got %0d want %0d", got.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            total_cnt++;
            if (g !== exp_q[i]) $display("FAIL bp_byte%0d got %h want %h", i, g, exp_q[i]); else pass_cnt++;
        end
        total_cnt++;
        if (overflow !== 1'b1) $display("FAIL bp_sticky got %b want 1", overflow); else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [7:0] exp_fl [5] = '{8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A};
        logic [7:0] g;
        bit ok;
        do_reset();
        for (int i = 0; i < 3; i++) push_letter(5'(i));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_bytes(5, 60, ok);
        idle(10);
        total_cnt++;
        if (got.size() != 5) $display("FAIL flush_count got %0d want 5", got.size()); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            total_cnt++;
            if (g !== exp_fl[i]) $display("FAIL flush_byte%0d got %h want %h", i, g, exp_fl[i]); else pass_cnt++;
        end
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL flush_idle got %b want 0", tx_valid); else pass_cnt++;
        got.delete();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idle(10);
        total_cnt++;
        if (got.size() != 0) $display("FAIL flush_empty got %0d bytes want 0", got.size()); else pass_cnt++;
    endtask

    task automatic test_qmark_full();
        logic [7:0] g;
        bit ok;
        do_reset();
        push_letter(5'd27);
        wait_bytes(1, 20, ok);
        g = (got.size() > 0) ? got[0] : 8'hxx;
        total_cnt++;
        if (g !== 8'h3F) $display("FAIL qmark got %h want 3f", g); else pass_cnt++;
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) push_letter(5'(i));
        total_cnt++;
        if (level !== 5'd16) $display("FAIL full_pre_level got %0d want 16", level); else pass_cnt++;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        // Handshake just completed; the IDLE cycle now pops while we push.
        tx_ready = 1'b0;
        valid_in = 1'b1;
        char_in  = 5'd20;
        sent.push_back(5'd20);
        @(posedge clk); #1;
        valid_in = 1'b0;
        total_cnt++;
        if (level !== 5'd16) $display("FAIL pushpop_level got %0d want 16", level); else pass_cnt++;
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL pushpop_overflow got %b want 0", overflow); else pass_cnt++;
        tx_ready = 1'b1;
        model_build();
        wait_bytes(exp_q.size(), 100, ok);
        idle(10);
        total_cnt++;
        if (got.size() != exp_q.size()) $display("FAIL pushpop_count got %0d want %0d", got.size(), exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            total_cnt++;
            if (g !== exp_q[i]) $display("FAIL pushpop_byte%0d got %h want %h", i, g, exp_q[i]); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] g0, g1;
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_letter(5'(i));
            idle(2);
        end
        wait_bytes(4, 40, ok);
        tx_ready = 1'b0;
        push_letter(5'd4);
        push_letter(5'd5);
        push_letter(5'd6);
        idle(2);
        total_cnt++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h45) $display("FAIL arst_pre got valid=%b data=%h want 1/45", tx_valid, tx_data); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL arst_tx_valid got %b want 0", tx_valid); else pass_cnt++;
        total_cnt++;
        if (level !== 5'd0) $display("FAIL arst_level got %0d want 0", level); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        got.delete();
        sent.delete();
        tx_ready = 1'b1;
        push_letter(5'd7);
        push_letter(5'd8);
        wait_bytes(2, 20, ok);
        idle(10);
        total_cnt++;
        if (got.size() != 2) $display("FAIL arst_count got %0d want 2", got.size()); else pass_cnt++;
        g0 = (got.size() > 0) ? got[0] : 8'hxx;
        g1 = (got.size() > 1) ? got[1] : 8'hxx;
        total_cnt++;
        if (g0 !== 8'h48 || g1 !== 8'h49) $display("FAIL arst_bytes got %h %h want 48 49", g0, g1); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_group();
        test_line();
        test_backpressure();
        test_flush();
        test_qmark_full();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
